// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: stall/bubble/flush/redirect control from EX flush, halt, load-use and memory back-pressure.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipeline_ctrl #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LU_CYCLES  = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic                  ex_load_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_flush,
    input  logic [ADDR_W-1:0]     ex_flush_addr,
    input  logic                  ex_halt,
    input  logic                  mem_busy,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  bubble_ex,
    output logic                  flush_front,
    output logic                  redirect_valid,
    output logic [ADDR_W-1:0]     redirect_addr,
    output logic                  halted,
    output logic [CNT_W-1:0]      cnt_stall,
    output logic [CNT_W-1:0]      cnt_flush,
    output logic [CNT_W-1:0]      cnt_bubble
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, HALTED} state_e;

    localparam logic [2:0] LU_LOAD = 3'(LU_CYCLES - 1);

    state_e              state_q, state_d, eff_state;
    logic                pending_q, pending_d;
    logic [ADDR_W-1:0]   pending_addr_q, pending_addr_d;
    logic [2:0]          lu_cnt_q, lu_cnt_d;
    logic                hazard;

    assign hazard = id_valid && ex_load_valid && (ex_rd_addr != '0) &&
                    ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                     (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        pending_addr_d = pending_addr_q;
        lu_cnt_d       = lu_cnt_q;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        bubble_ex      = 1'b0;
        flush_front    = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halted         = 1'b0;

        // Leaving a freeze without a held redirect resumes whatever the pipe was doing before it.
        eff_state = state_q;
        if (state_q == MEM_WAIT) begin
            eff_state = (lu_cnt_q != 3'd0) ? LU_STALL : RUN;
        end

        if (!reset) begin
            if (state_q == HALTED) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                halted   = 1'b1;
            end else if (mem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                if (ex_flush && !pending_q) begin
                    pending_d      = 1'b1;
                    pending_addr_d = ex_flush_addr;
                end
                state_d = MEM_WAIT;
            end else if ((state_q == MEM_WAIT) && pending_q) begin
                redirect_valid = 1'b1;
                redirect_addr  = pending_addr_q;
                flush_front    = 1'b1;
                pending_d      = 1'b0;
                lu_cnt_d       = 3'd0;
                state_d        = RUN;
            end else if (ex_flush) begin
                redirect_valid = 1'b1;
                redirect_addr  = ex_flush_addr;
                flush_front    = 1'b1;
                lu_cnt_d       = 3'd0;
                state_d        = RUN;
            end else if (ex_halt) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                state_d  = HALTED;
            end else if (eff_state == LU_STALL) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
                lu_cnt_d  = lu_cnt_q - 3'd1;
                state_d   = (lu_cnt_q == 3'd1) ? RUN : LU_STALL;
            end else begin
                state_d = RUN;
                if (hazard) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    lu_cnt_d  = LU_LOAD;
                    state_d   = (LU_CYCLES > 1) ? LU_STALL : RUN;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            pending_q      <= 1'b0;
            pending_addr_q <= '0;
            lu_cnt_q       <= 3'd0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            pending_addr_q <= pending_addr_d;
            lu_cnt_q       <= lu_cnt_d;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q, cnt_bubble_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_stall_q  <= '0;
            cnt_flush_q  <= '0;
            cnt_bubble_q <= '0;
        end else if (state_q != HALTED) begin
            if (stall_ex)       cnt_stall_q  <= cnt_stall_q + CNT_W'(1);
            if (redirect_valid) cnt_flush_q  <= cnt_flush_q + CNT_W'(1);
            if (bubble_ex)      cnt_bubble_q <= cnt_bubble_q + CNT_W'(1);
        end
    end

    assign cnt_stall  = cnt_stall_q;
    assign cnt_flush  = cnt_flush_q;
    assign cnt_bubble = cnt_bubble_q;
`else
    assign cnt_stall  = '0;
    assign cnt_flush  = '0;
    assign cnt_bubble = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: two instances (LU_CYCLES = 1 and 3) share one stimulus stream.
module tb_pipeline_ctrl;

    localparam int ADDR_W = 32;
    localparam int RA_W   = 5;
    localparam int CNT_W  = 32;

    // Control vector layout: {stall_if, stall_id, stall_ex, bubble_ex, flush_front, redirect_valid, halted}
    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] HAZ   = 7'b1101000;
    localparam logic [6:0] FRZ   = 7'b1110000;
    localparam logic [6:0] RDR   = 7'b0000110;
    localparam logic [6:0] HALTD = 7'b1110001;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid, id_rs1_used, id_rs2_used, ex_load_valid;
    logic [RA_W-1:0]   id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic              ex_flush, ex_halt, mem_busy;
    logic [ADDR_W-1:0] ex_flush_addr;

    logic              sif1, sid1, sex1, bub1, ff1, rv1, hlt1;
    logic              sif3, sid3, sex3, bub3, ff3, rv3, hlt3;
    logic [ADDR_W-1:0] raddr1, raddr3;
    logic [CNT_W-1:0]  cs1, cf1, cb1, cs3, cf3, cb3;
    logic [6:0]        ctl1, ctl3;

    assign ctl1 = {sif1, sid1, sex1, bub1, ff1, rv1, hlt1};
    assign ctl3 = {sif3, sid3, sex3, bub3, ff3, rv3, hlt3};

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.ADDR_W(ADDR_W), .REG_ADDR_W(RA_W), .LU_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_load_valid(ex_load_valid), .ex_rd_addr(ex_rd_addr),
        .ex_flush(ex_flush), .ex_flush_addr(ex_flush_addr), .ex_halt(ex_halt), .mem_busy(mem_busy),
        .stall_if(sif1), .stall_id(sid1), .stall_ex(sex1), .bubble_ex(bub1),
        .flush_front(ff1), .redirect_valid(rv1), .redirect_addr(raddr1), .halted(hlt1),
        .cnt_stall(cs1), .cnt_flush(cf1), .cnt_bubble(cb1)
    );

    pipeline_ctrl #(.ADDR_W(ADDR_W), .REG_ADDR_W(RA_W), .LU_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_load_valid(ex_load_valid), .ex_rd_addr(ex_rd_addr),
        .ex_flush(ex_flush), .ex_flush_addr(ex_flush_addr), .ex_halt(ex_halt), .mem_busy(mem_busy),
        .stall_if(sif3), .stall_id(sid3), .stall_ex(sex3), .bubble_ex(bub3),
        .flush_front(ff3), .redirect_valid(rv3), .redirect_addr(raddr3), .halted(hlt3),
        .cnt_stall(cs3), .cnt_flush(cf3), .cnt_bubble(cb3)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid      = 1'b0;
        id_rs1_addr   = '0;
        id_rs2_addr   = '0;
        id_rs1_used   = 1'b0;
        id_rs2_used   = 1'b0;
        ex_load_valid = 1'b0;
        ex_rd_addr    = '0;
        ex_flush      = 1'b0;
        ex_flush_addr = '0;
        ex_halt       = 1'b0;
        mem_busy      = 1'b0;
    endtask

    // ID reads x5 (rs1) and x7 (rs2); EX holds a load to rd.
    task automatic set_hazard(input logic [RA_W-1:0] rd);
        id_valid      = 1'b1;
        id_rs1_addr   = 5'd5;
        id_rs1_used   = 1'b1;
        id_rs2_addr   = 5'd7;
        id_rs2_used   = 1'b1;
        ex_load_valid = 1'b1;
        ex_rd_addr    = rd;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        set_hazard(5'd5);
        ex_flush      = 1'b1;
        ex_flush_addr = 32'h0000_0100;
        ex_halt       = 1'b1;
        #1;
        vectors++;
        if (ctl1 !== NONE || raddr1 !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_dut1: got ctl=%b addr=%h want ctl=%b addr=0", ctl1, raddr1, NONE);
        end
        vectors++;
        if (ctl3 !== NONE || raddr3 !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs_dut3: got ctl=%b addr=%h want ctl=%b addr=0", ctl3, raddr3, NONE);
        end
        vectors++;
        if ({cs1, cf1, cb1, cs3, cf3, cb3} !== '0) begin
            miscompares++;
            $display("FAIL reset_counters: got %0d %0d %0d %0d %0d %0d want all 0", cs1, cf1, cb1, cs3, cf3, cb3);
        end
        cyc();
        idle_inputs();
        reset = 1'b0;
        #1;
        vectors++;
        if (ctl1 !== NONE || ctl3 !== NONE) begin
            miscompares++;
            $display("FAIL reset_release_idle: got ctl1=%b ctl3=%b want %b", ctl1, ctl3, NONE);
        end
        cyc();
    endtask

    task automatic test_load_use();
        logic [RA_W-1:0] rd_t   [5] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd5};
        logic [RA_W-1:0] rs1_t  [5] = '{5'd5, 5'd0, 5'd5, 5'd5, 5'd5};
        logic            rs2u_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic            vld_t  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [6:0]      exp_t  [5] = '{HAZ,  NONE, NONE, HAZ,  NONE};
        for (int i = 0; i < 5; i++) begin
            set_hazard(rd_t[i]);
            id_rs1_addr = rs1_t[i];
            id_rs2_used = rs2u_t[i];
            id_valid    = vld_t[i];
            #1;
            vectors++;
            if (ctl1 !== exp_t[i]) begin
                miscompares++;
                $display("FAIL load_use_%0d: got ctl=%b want %b", i, ctl1, exp_t[i]);
            end
            cyc();
            idle_inputs();
            #1;
            vectors++;
            if (ctl1 !== NONE) begin
                miscompares++;
                $display("FAIL load_use_after_%0d: got ctl=%b want %b", i, ctl1, NONE);
            end
            cyc();
        end
    endtask

    task automatic test_lu3_with_freeze();
        logic       busy_t [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [6:0] exp_t  [6] = '{HAZ,  HAZ,  FRZ,  FRZ,  HAZ,  NONE};
        int bubbles = 0;
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            if (i == 0) set_hazard(5'd5);
            mem_busy = busy_t[i];
            #1;
            vectors++;
            if (ctl3 !== exp_t[i]) begin
                miscompares++;
                $display("FAIL lu3_freeze_c%0d: got ctl=%b want %b", i, ctl3, exp_t[i]);
            end
            if (bub3) bubbles++;
            cyc();
        end
        vectors++;
        if (bubbles !== 3) begin
            miscompares++;
            $display("FAIL lu3_bubble_total: got %0d want 3", bubbles);
        end
        idle_inputs();
        set_hazard(5'd7);
        #1;
        vectors++;
        if (ctl3 !== HAZ) begin
            miscompares++;
            $display("FAIL lu3_abort_start: got ctl=%b want %b", ctl3, HAZ);
        end
        cyc();
        idle_inputs();
        ex_flush      = 1'b1;
        ex_flush_addr = 32'h0000_0180;
        #1;
        vectors++;
        if (ctl3 !== RDR || raddr3 !== 32'h0000_0180) begin
            miscompares++;
            $display("FAIL lu3_abort_flush: got ctl=%b addr=%h want %b addr=00000180", ctl3, raddr3, RDR);
        end
        cyc();
        idle_inputs();
        #1;
        vectors++;
        if (ctl3 !== NONE) begin
            miscompares++;
            $display("FAIL lu3_abort_after: got ctl=%b want %b", ctl3, NONE);
        end
        cyc();
    endtask

    task automatic test_flush_over_hazard();
        idle_inputs();
        set_hazard(5'd5);
        ex_flush      = 1'b1;
        ex_flush_addr = 32'h0000_0100;
        #1;
        vectors++;
        if (ctl1 !== RDR || raddr1 !== 32'h0000_0100) begin
            miscompares++;
            $display("FAIL flush_hazard: got ctl=%b addr=%h want %b addr=00000100", ctl1, raddr1, RDR);
        end
        cyc();
        idle_inputs();
        #1;
        vectors++;
        if (ctl1 !== NONE || raddr1 !== '0) begin
            miscompares++;
            $display("FAIL flush_hazard_after: got ctl=%b addr=%h want %b addr=0", ctl1, raddr1, NONE);
        end
        cyc();
    endtask

    task automatic test_flush_during_busy();
        logic              busy_t [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic              fl_t   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [ADDR_W-1:0] fa_t   [5] = '{32'h200, 32'h0, 32'h300, 32'h0, 32'h0};
        logic [6:0]        exp_t  [5] = '{FRZ, FRZ, FRZ, RDR, NONE};
        logic [ADDR_W-1:0] ea_t   [5] = '{32'h0, 32'h0, 32'h0, 32'h200, 32'h0};
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            mem_busy      = busy_t[i];
            ex_flush      = fl_t[i];
            ex_flush_addr = fa_t[i];
            #1;
            vectors++;
            if (ctl1 !== exp_t[i] || raddr1 !== ea_t[i]) begin
                miscompares++;
                $display("FAIL busy_flush_c%0d: got ctl=%b addr=%h want ctl=%b addr=%h",
                         i, ctl1, raddr1, exp_t[i], ea_t[i]);
            end
            cyc();
        end
    endtask

    task automatic test_halt();
        idle_inputs();
        ex_flush      = 1'b1;
        ex_flush_addr = 32'h0000_0040;
        ex_halt       = 1'b1;
        #1;
        vectors++;
        if (ctl1 !== RDR || raddr1 !== 32'h0000_0040) begin
            miscompares++;
            $display("FAIL halt_flush_priority: got ctl=%b addr=%h want %b addr=00000040", ctl1, raddr1, RDR);
        end
        cyc();
        idle_inputs();
        ex_halt = 1'b1;
        #1;
        vectors++;
        if (ctl1 !== FRZ) begin
            miscompares++;
            $display("FAIL halt_request: got ctl=%b want %b", ctl1, FRZ);
        end
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            if (i == 1) begin
                ex_flush      = 1'b1;
                ex_flush_addr = 32'h0000_0400;
            end
            if (i == 2) begin
                mem_busy = 1'b1;
                set_hazard(5'd5);
            end
            #1;
            vectors++;
            if (ctl1 !== HALTD || raddr1 !== '0) begin
                miscompares++;
                $display("FAIL halted_hold_%0d: got ctl=%b addr=%h want %b addr=0", i, ctl1, raddr1, HALTD);
            end
            cyc();
        end
        do_reset();
        #1;
        vectors++;
        if (ctl1 !== NONE) begin
            miscompares++;
            $display("FAIL halt_cleared_by_reset: got ctl=%b want %b", ctl1, NONE);
        end
        cyc();
    endtask

    task automatic test_perf_counters();
        logic [CNT_W-1:0] exp_b, exp_f, exp_s1, exp_s2;
`ifdef PIPE_PERF_EN
        exp_b  = 2;
        exp_f  = 1;
        exp_s1 = 0;
        exp_s2 = 1;
`else
        exp_b  = 0;
        exp_f  = 0;
        exp_s1 = 0;
        exp_s2 = 0;
`endif
        do_reset();
        set_hazard(5'd5);
        cyc();
        set_hazard(5'd5);
        cyc();
        idle_inputs();
        ex_flush      = 1'b1;
        ex_flush_addr = 32'h0000_0040;
        cyc();
        idle_inputs();
        #1;
        vectors++;
        if (cb1 !== exp_b || cf1 !== exp_f || cs1 !== exp_s1) begin
            miscompares++;
            $display("FAIL perf_dut1: got bubble=%0d flush=%0d stall=%0d want %0d %0d %0d",
                     cb1, cf1, cs1, exp_b, exp_f, exp_s1);
        end
        vectors++;
        if (cb3 !== exp_b || cf3 !== exp_f || cs3 !== exp_s1) begin
            miscompares++;
            $display("FAIL perf_dut3: got bubble=%0d flush=%0d stall=%0d want %0d %0d %0d",
                     cb3, cf3, cs3, exp_b, exp_f, exp_s1);
        end
        ex_halt = 1'b1;
        cyc();
        idle_inputs();
        cyc();
        cyc();
        #1;
        vectors++;
        if (cs1 !== exp_s2 || cb1 !== exp_b || cf1 !== exp_f) begin
            miscompares++;
            $display("FAIL perf_halt_freeze: got stall=%0d bubble=%0d flush=%0d want %0d %0d %0d",
                     cs1, cb1, cf1, exp_s2, exp_b, exp_f);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({cs1, cf1, cb1, cs3, cf3, cb3} !== '0 || ctl1 !== NONE || ctl3 !== NONE) begin
            miscompares++;
            $display("FAIL perf_async_reset: got cnt1=%0d/%0d/%0d ctl1=%b ctl3=%b want all 0",
                     cs1, cf1, cb1, ctl1, ctl3);
        end
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_lu3_with_freeze();
        test_flush_over_hazard();
        test_flush_during_busy();
        test_halt();
        test_perf_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
